ovf_event_logger: RTL

OVF_EVENT_LOGGER -- requirements
Module: ovf_event_logger

---
 rtl/ovf_event_logger.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ovf_event_logger.sv
// Overflow event logger: detects rising edges of an upstream overflow flag and
// queues {sequence, counter snapshot} records in a first-word-fall-through FIFO.
`timescale 1ns/1ps
module ovf_event_logger #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CNT_W-1:0]         counter_in,
  input  logic                     overflow_in,
  input  logic                     evt_ready,
  input  logic                     clear_drop,
  output logic                     evt_valid,
  output logic [7:0]               evt_seq,
  output logic [CNT_W-1:0]         evt_snap,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     dropped,
  output logic [7:0]               drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned RW = 8 + CNT_W;

  logic          r_ovf_q;
  logic [7:0]    r_seq;
  logic [RW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_evt_valid;
  logic [RW-1:0] r_head;
  logic          r_dropped;
  logic [7:0]    r_drop_count;

  logic          w_evt;
  logic          w_pop;
  logic          w_full;
  logic          w_push;
  logic          w_drop;
  logic [RW-1:0] w_rec;
  logic [AW-1:0] w_rd_nxt;
  logic [AW-1:0] w_wr_nxt;
  logic [LW-1:0] w_level_nxt;
  logic          w_valid_nxt;
  logic [RW-1:0] w_head_nxt;

  // Edge detect, push/pop arbitration and next head selection.
  always_comb begin
    w_evt       = overflow_in & ~r_ovf_q;
    w_pop       = r_evt_valid & evt_ready;
    w_full      = (r_level == LW'(DEPTH));
    w_push      = w_evt & (~w_full | w_pop);
    w_drop      = w_evt & w_full & ~w_pop;
    w_rec       = {r_seq, counter_in};
    w_rd_nxt    = w_pop  ? r_rd_ptr + AW'(1) : r_rd_ptr;
    w_wr_nxt    = w_push ? r_wr_ptr + AW'(1) : r_wr_ptr;
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + LW'(1);
    end else if (w_pop && !w_push) begin
      w_level_nxt = r_level - LW'(1);
    end
    w_valid_nxt = (w_level_nxt != '0);
    w_head_nxt  = '0;
    // The freshly pushed record becomes head only when it lands on the next read slot.
    if (w_valid_nxt) begin
      if (w_push && (w_rd_nxt == r_wr_ptr)) begin
        w_head_nxt = w_rec;
      end else begin
        w_head_nxt = r_mem[w_rd_nxt];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_rec;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf_q      <= 1'b0;
      r_seq        <= 8'd0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_evt_valid  <= 1'b0;
      r_head       <= '0;
      r_dropped    <= 1'b0;
      r_drop_count <= 8'd0;
    end else begin
      r_ovf_q     <= overflow_in;
      r_wr_ptr    <= w_wr_nxt;
      r_rd_ptr    <= w_rd_nxt;
      r_level     <= w_level_nxt;
      r_evt_valid <= w_valid_nxt;
      r_head      <= w_head_nxt;
      if (w_evt) begin
        r_seq <= r_seq + 8'd1;
      end
      // A drop in the clearing cycle wins and restarts the count at one.
      if (w_drop) begin
        r_dropped <= 1'b1;
        if (clear_drop) begin
          r_drop_count <= 8'd1;
        end else if (r_drop_count != 8'hFF) begin
          r_drop_count <= r_drop_count + 8'd1;
        end
      end else if (clear_drop) begin
        r_dropped    <= 1'b0;
        r_drop_count <= 8'd0;
      end
    end
  end

  assign evt_valid  = r_evt_valid;
  assign evt_seq    = r_head[RW-1:CNT_W];
  assign evt_snap   = r_head[CNT_W-1:0];
  assign fifo_level = r_level;
  assign dropped    = r_dropped;
  assign drop_count = r_drop_count;

endmodule
